// File: rtl/line_buffer_ctrl_pkg.sv
// rtl/line_buffer_ctrl_pkg.sv - shared types and helpers for the line buffer frame sequencer
package line_buffer_ctrl_pkg;

    typedef enum logic [1:0] {
        LBC_IDLE,
        LBC_STREAM,
        LBC_FLUSH,
        LBC_DONE
    } lbc_state_e;

    // Complete KxK windows produced by one w x h frame.
    function automatic int win_count(input int w, input int h, input int k);
        return (h - k + 1) * (w - k + 1);
    endfunction

endpackage

// File: rtl/line_buffer_ctrl_if.sv
// rtl/line_buffer_ctrl_if.sv - pixel input and window output handshakes of the frame sequencer
interface line_buffer_ctrl_if #(
    parameter int ROW_W = 4,
    parameter int COL_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic             lb_en;
    logic             win_valid;
    logic             win_ready;
    logic [ROW_W-1:0] win_row;
    logic [COL_W-1:0] win_col;

    // slave: the controller; master: pixel source plus window consumer
    modport slave (
        input  in_valid, win_ready,
        output in_ready, lb_en, win_valid, win_row, win_col
    );

    modport master (
        output in_valid, win_ready,
        input  in_ready, lb_en, win_valid, win_row, win_col
    );
endinterface

// File: rtl/line_buffer_ctrl_wrap_counter.sv
// rtl/line_buffer_ctrl_wrap_counter.sv - modulo-MAX counter with a combinational wrap strobe
module wrap_counter #(
    parameter  int MAX = 10,
    localparam int CW  = (MAX > 1) ? $clog2(MAX) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          wrap
);
    localparam logic [CW-1:0] LAST = CW'(MAX - 1);

    // wrap fires on the enabled step that returns the count to zero
    assign wrap = en & (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + CW'(1);
        end
    end
endmodule

// File: rtl/line_buffer_ctrl.sv
// rtl/line_buffer_ctrl.sv - frame sequencer driving a KERNEL_SIZE-row line buffer chain
module line_buffer_ctrl
    import line_buffer_ctrl_pkg::*;
#(
    parameter int IMG_WIDTH   = 10,
    parameter int IMG_HEIGHT  = 10,
    parameter int KERNEL_SIZE = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    line_buffer_ctrl_if.slave    bus
);
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] K_COL = COL_W'(KERNEL_SIZE - 1);
    localparam logic [ROW_W-1:0] K_ROW = ROW_W'(KERNEL_SIZE - 1);

    lbc_state_e       state;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             col_wrap;
    logic             last_pixel;
    logic             accept;
    logic             qualify;

    // A pending window blocks new pixels unless it is being consumed this cycle.
    assign bus.in_ready = (state == LBC_STREAM) && (!bus.win_valid || bus.win_ready) && !abort;
    assign accept       = bus.in_valid & bus.in_ready;
    assign bus.lb_en    = accept;
    assign qualify      = accept && (row >= K_ROW) && (col >= K_COL);

    wrap_counter #(.MAX(IMG_WIDTH)) u_col (
        .clk  (clk),
        .rst  (rst),
        .clr  (abort),
        .en   (accept),
        .cnt  (col),
        .wrap (col_wrap)
    );

    // Row wrap coincides with accepting the frame's bottom-right pixel.
    wrap_counter #(.MAX(IMG_HEIGHT)) u_row (
        .clk  (clk),
        .rst  (rst),
        .clr  (abort),
        .en   (col_wrap),
        .cnt  (row),
        .wrap (last_pixel)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= LBC_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            bus.win_valid <= 1'b0;
            bus.win_row   <= '0;
            bus.win_col   <= '0;
        end else if (abort) begin
            state         <= LBC_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            bus.win_valid <= 1'b0;
            bus.win_row   <= '0;
            bus.win_col   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                LBC_IDLE: begin
                    if (start) begin
                        state <= LBC_STREAM;
                        busy  <= 1'b1;
                    end
                end
                LBC_STREAM: begin
                    if (last_pixel) state <= LBC_FLUSH;
                end
                LBC_FLUSH: begin
                    if (!bus.win_valid || bus.win_ready) begin
                        state <= LBC_DONE;
                        done  <= 1'b1;
                    end
                end
                LBC_DONE: begin
                    state <= LBC_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= LBC_IDLE;
            endcase

            // One cycle behind the accept, aligned with the line buffer output delay.
            if (qualify) begin
                bus.win_valid <= 1'b1;
                bus.win_row   <= row;
                bus.win_col   <= col;
            end else if (bus.win_ready) begin
                bus.win_valid <= 1'b0;
            end
        end
    end
endmodule
